// File: rtl/timer_nivel2_pkg.sv
// Shared definitions for the level-2 cook timer.
//   state_t          : FSM encoding (IDLE/SET/RUN/DONE, 2 bits)
//   BCD_W            : width of one BCD digit
//   BCD_MAX          : reload value of a digit that counts 9..0
//   SEC_TENS_RELOAD  : reload value of the seconds-tens digit (x9 -> x5:9)
//   NUM_DIGITS       : number of display digits (MM:SS)
package timer_nivel2_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SET  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int BCD_W           = 4;
    localparam int BCD_MAX         = 9;
    localparam int SEC_TENS_RELOAD = 5;
    localparam int NUM_DIGITS      = 4;
endpackage

// File: rtl/timer_nivel2_bcd_down_digit.sv
// One BCD digit of the countdown chain.
//   clk, reset   : system clock, synchronous active-high reset
//   clr          : synchronous clear to 0
//   load_en      : load load_val (keypad shift)
//   load_val     : value to load
//   dec_en       : decrement this digit by one (borrow in)
//   reload       : value taken when decrementing from 0
//   digit        : current digit value
//   borrow_out   : high when this digit wraps, i.e. the next digit must decrement
module bcd_down_digit
    import timer_nivel2_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load_en,
    input  logic [BCD_W-1:0] load_val,
    input  logic             dec_en,
    input  logic [BCD_W-1:0] reload,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);
    assign borrow_out = dec_en && (digit == '0);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            digit <= '0;
        end else if (load_en) begin
            digit <= load_val;
        end else if (dec_en) begin
            // digits above 5 in the seconds-tens place count down as-is
            digit <= (digit == '0) ? reload : digit - 1'b1;
        end
    end
endmodule

// File: rtl/timer_nivel2.sv
// Level-2 microwave cook timer. Keypad digits shift in as MM:SS (BCD); the
// count decrements once per TICK_CYCLES clocks while running and raises
// timer_done on reaching 00:00.
//   clk, reset   : system clock, synchronous active-high reset
//   clearn       : keypad clear, active-low, synchronous
//   digit_valid  : strobe for digit_in
//   digit_in     : BCD keypad digit, 10..15 ignored
//   mag_on       : magnetron on; enables counting
//   timer_done   : count reached 00:00 (level, held until clear/entry)
//   running      : high in RUN
//   min_tens, min_ones, sec_tens, sec_ones : display digits
module timer_nivel2
    import timer_nivel2_pkg::*;
#(
    parameter int TICK_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clearn,
    input  logic             digit_valid,
    input  logic [BCD_W-1:0] digit_in,
    input  logic             mag_on,
    output logic             timer_done,
    output logic             running,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    state_t  state, next_state;
    logic [PW-1:0] prescaler;

    // index 0 = sec_ones ... 3 = min_tens
    logic [NUM_DIGITS-1:0][BCD_W-1:0] digits;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] load_val;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] reload;
    logic [NUM_DIGITS-1:0]            dec_en;
    logic [NUM_DIGITS-1:0]            borrow;

    logic clear, entry, tick, final_tick, entry_nonzero;

    assign clear = !clearn;
    assign entry = digit_valid && (digit_in <= BCD_W'(BCD_MAX)) && (state != S_RUN);
    // a tick completes even if mag_on drops on that edge
    assign tick  = (state == S_RUN) && (prescaler == PW'(TICK_CYCLES - 1));
    // the only value that decrements to 00:00 is 00:01
    assign final_tick = tick && (digits == {{(NUM_DIGITS-1)*BCD_W{1'b0}}, BCD_W'(1)});
    assign entry_nonzero = (digits[2:0] != '0) || (digit_in != '0);

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = S_IDLE;
        end else if (entry) begin
            next_state = entry_nonzero ? S_SET : S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (mag_on) next_state = S_DONE;
                S_SET:  if (mag_on) next_state = S_RUN;
                S_RUN: begin
                    if (final_tick)   next_state = S_DONE;
                    else if (!mag_on) next_state = S_SET;
                end
                default: next_state = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            prescaler  <= '0;
            running    <= 1'b0;
            timer_done <= 1'b0;
        end else begin
            state      <= next_state;
            running    <= (next_state == S_RUN);
            timer_done <= (next_state == S_DONE);
            if (clear || entry) begin
                prescaler <= '0;
            end else if (tick) begin
                prescaler <= '0;
            end else if (state == S_RUN && mag_on) begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
            if (i == 0) begin : g_lsd
                assign load_val[i] = digit_in;
                assign dec_en[i]   = tick && !clear;
            end else begin : g_hsd
                assign load_val[i] = digits[i-1];
                assign dec_en[i]   = borrow[i-1];
            end
            assign reload[i] = (i == 1) ? BCD_W'(SEC_TENS_RELOAD) : BCD_W'(BCD_MAX);

            bcd_down_digit u_digit (
                .clk        (clk),
                .reset      (reset),
                .clr        (clear),
                .load_en    (entry),
                .load_val   (load_val[i]),
                .dec_en     (dec_en[i]),
                .reload     (reload[i]),
                .digit      (digits[i]),
                .borrow_out (borrow[i])
            );
        end
    endgenerate

    assign sec_ones = digits[0];
    assign sec_tens = digits[1];
    assign min_ones = digits[2];
    assign min_tens = digits[3];
endmodule

// File: tb/tb_timer_nivel2.sv
module tb_timer_nivel2;
    logic       clk = 1'b0;
    logic       reset, clearn, digit_valid, mag_on;
    logic [3:0] digit_in;
    logic       timer_done, running;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timer_nivel2 #(.TICK_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .clearn      (clearn),
        .digit_valid (digit_valid),
        .digit_in    (digit_in),
        .mag_on      (mag_on),
        .timer_done  (timer_done),
        .running     (running),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones)
    );

    wire [15:0] disp = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [3:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        step(1);
        digit_valid = 1'b0;
        digit_in    = 4'd0;
    endtask

    task automatic clr_pulse();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    initial begin
        reset = 1'b1; clearn = 1'b1; digit_valid = 1'b0; digit_in = 4'd0; mag_on = 1'b0;
        step(2);
        chk("rst_disp", {16'd0, disp}, 32'h0000);
        chk("rst_done", {31'd0, timer_done}, 32'd0);
        chk("rst_run",  {31'd0, running}, 32'd0);
        reset = 1'b0;

        // 1: 00:03, done at edge 12 after entering RUN
        enter(4'd0); enter(4'd3);
        chk("t1_load", {16'd0, disp}, 32'h0003);
        mag_on = 1'b1;
        step(1);  chk("t1_run", {31'd0, running}, 32'd1);
        step(3);  chk("t1_pre3", {16'd0, disp}, 32'h0003);
        step(1);  chk("t1_dec1", {16'd0, disp}, 32'h0002);
        step(4);  chk("t1_dec2", {16'd0, disp}, 32'h0001);
        step(3);  chk("t1_notyet", {31'd0, timer_done}, 32'd0);
        step(1);  chk("t1_zero", {16'd0, disp}, 32'h0000);
        chk("t1_done", {31'd0, timer_done}, 32'd1);
        chk("t1_stop", {31'd0, running}, 32'd0);

        // 5: clear at DONE, then zero-time start
        clr_pulse();
        chk("t5_clr_done", {31'd0, timer_done}, 32'd0);
        chk("t5_clr_disp", {16'd0, disp}, 32'h0000);
        step(1);  chk("t5_zero_start", {31'd0, timer_done}, 32'd1);
        mag_on = 1'b0;

        // 2: 01:00 -> 00:59 -> 00:58 (entry leaves DONE)
        enter(4'd1);
        chk("t2_entry_clr_done", {31'd0, timer_done}, 32'd0);
        enter(4'd0); enter(4'd0);
        chk("t2_load", {16'd0, disp}, 32'h0100);
        mag_on = 1'b1;
        step(1);
        step(4);  chk("t2_borrow", {16'd0, disp}, 32'h0059);
        step(4);  chk("t2_dec", {16'd0, disp}, 32'h0058);
        mag_on = 1'b0;
        step(1);  chk("t2_pause", {31'd0, running}, 32'd0);

        // 4: ignored entries
        enter(4'd12); chk("t4_bad_digit", {16'd0, disp}, 32'h0058);
        mag_on = 1'b1;
        step(1);
        enter(4'd7);  chk("t4_run_entry", {16'd0, disp}, 32'h0058);
        mag_on = 1'b0;
        step(1);
        clr_pulse();

        // 3: pause holds prescaler
        enter(4'd0); enter(4'd5);
        mag_on = 1'b1;
        step(1);
        step(4);  chk("t3_dec", {16'd0, disp}, 32'h0004);
        step(2);
        mag_on = 1'b0;
        step(10); chk("t3_frozen", {16'd0, disp}, 32'h0004);
        chk("t3_paused", {31'd0, running}, 32'd0);
        mag_on = 1'b1;
        step(1);  chk("t3_resume", {31'd0, running}, 32'd1);
        step(1);  chk("t3_hold", {16'd0, disp}, 32'h0004);
        step(1);  chk("t3_resume_dec", {16'd0, disp}, 32'h0003);

        // 6: reset mid-RUN at 00:02
        step(4);  chk("t6_at2", {16'd0, disp}, 32'h0002);
        reset = 1'b1;
        step(1);
        reset = 1'b0; mag_on = 1'b0;
        chk("t6_rst_disp", {16'd0, disp}, 32'h0000);
        chk("t6_rst_run",  {31'd0, running}, 32'd0);
        chk("t6_rst_done", {31'd0, timer_done}, 32'd0);

        // 6: clear on the final tick
        enter(4'd0); enter(4'd2);
        mag_on = 1'b1;
        step(1);
        step(4);  chk("t6_at1", {16'd0, disp}, 32'h0001);
        step(3);
        clearn = 1'b0;
        step(1);
        clearn = 1'b1; mag_on = 1'b0;
        chk("t6_clr_tick_done", {31'd0, timer_done}, 32'd0);
        chk("t6_clr_tick_disp", {16'd0, disp}, 32'h0000);
        step(2);  chk("t6_never_done", {31'd0, timer_done}, 32'd0);

        // 00:90 decrements un-normalised; mag_on falling on a tick edge
        enter(4'd9); enter(4'd0);
        mag_on = 1'b1;
        step(1);
        step(4);  chk("x_sec90", {16'd0, disp}, 32'h0089);
        step(3);
        mag_on = 1'b0;
        step(1);  chk("x_fall_tick", {16'd0, disp}, 32'h0088);
        chk("x_fall_set", {31'd0, running}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
